// File: rtl/layer_sequencer.sv
// layer_sequencer: walks a programmable layer table and runs one CNN engine per
// entry through a start/done handshake. Each layer has a watchdog. The block
// also selects the ping-pong activation buffer that each layer reads.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   run, abort         run starts the table at entry 0; abort returns to IDLE
//   cfg_we/addr/engine/last  table write port, accepted only in IDLE
//   eng_start          one-hot, single-cycle start pulse to the selected engine
//   eng_done           per-engine completion pulses
//   buf_sel            buffer the current layer reads (0=A, 1=B)
//   layer_idx          current table entry
//   busy, done, error  status: busy outside IDLE, done pulse at end, sticky error
//
// Optional build macro LAYER_SEQ_PROFILE_EN adds the layer_cycles and
// total_cycles profiling outputs.
module layer_sequencer #(
  parameter int unsigned NUM_LAYERS     = 8,
  parameter int unsigned NUM_ENGINES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    run,
  input  logic                                                    abort,
  input  logic                                                    cfg_we,
  input  logic [$clog2(NUM_LAYERS > 1 ? NUM_LAYERS : 2)-1:0]      cfg_addr,
  input  logic [$clog2(NUM_ENGINES > 1 ? NUM_ENGINES : 2)-1:0]    cfg_engine,
  input  logic                                                    cfg_last,
  output logic [NUM_ENGINES-1:0]                                  eng_start,
  input  logic [NUM_ENGINES-1:0]                                  eng_done,
  output logic                                                    buf_sel,
  output logic [$clog2(NUM_LAYERS > 1 ? NUM_LAYERS : 2)-1:0]      layer_idx,
  output logic                                                    busy,
  output logic                                                    done,
  output logic                                                    error
`ifdef LAYER_SEQ_PROFILE_EN
  ,
  output logic [31:0]                                             layer_cycles,
  output logic [31:0]                                             total_cycles
`endif
);

  localparam int unsigned LW = $clog2(NUM_LAYERS > 1 ? NUM_LAYERS : 2);
  localparam int unsigned EW = $clog2(NUM_ENGINES > 1 ? NUM_ENGINES : 2);
  localparam int unsigned DW = 1 << EW;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES > 1 ? TIMEOUT_CYCLES : 2);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    ADVANCE,
    FINISH,
    ERROR
  } state_t;

  state_t          state;
  logic [EW-1:0]   tbl_engine [NUM_LAYERS];
  logic            tbl_last   [NUM_LAYERS];
  logic [TW-1:0]   timer;

  logic [EW-1:0]   cur_engine_c;
  logic            cur_last_c;
  logic            cur_done_c;
  logic            bad_engine_c;
  logic [DW-1:0]   done_ext_c;
  logic [DW-1:0]   start_vec_c;
  logic [TW-1:0]   timer_inc_c;

  // Current entry decode. eng_done is widened to the full index range, so an
  // out-of-range engine index never selects a real done bit.
  assign cur_engine_c = tbl_engine[layer_idx];
  assign cur_last_c   = tbl_last[layer_idx];
  assign done_ext_c   = DW'(eng_done);
  assign cur_done_c   = done_ext_c[cur_engine_c];
  assign start_vec_c  = DW'(1) << cur_engine_c;
  assign timer_inc_c  = timer + TW'(1);

  // An engine index can be out of range only when NUM_ENGINES is not a power of two.
  if (DW == NUM_ENGINES) begin : g_full_range
    assign bad_engine_c = 1'b0;
  end else begin : g_partial_range
    assign bad_engine_c = (cur_engine_c >= EW'(NUM_ENGINES));
  end

  // Sequencer FSM with its registered outputs and the layer table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      eng_start <= '0;
      buf_sel   <= 1'b0;
      layer_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      timer     <= '0;
`ifdef LAYER_SEQ_PROFILE_EN
      layer_cycles <= '0;
`endif
      for (int i = 0; i < NUM_LAYERS; i++) begin
        tbl_engine[i] <= '0;
        tbl_last[i]   <= 1'b1;
      end
    end else begin
      eng_start <= '0;
      done      <= 1'b0;
      // abort overrides run, eng_done and timeout; error is left as it is
      if (abort && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_we) begin
              tbl_engine[cfg_addr] <= cfg_engine;
              tbl_last[cfg_addr]   <= cfg_last;
            end
            if (run) begin
              state     <= ISSUE;
              layer_idx <= '0;
              buf_sel   <= 1'b0;
              error     <= 1'b0;
              busy      <= 1'b1;
            end
          end
          ISSUE: begin
            if (bad_engine_c) begin
              state <= ERROR;
            end else begin
              eng_start <= NUM_ENGINES'(start_vec_c);
              timer     <= '0;
              state     <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            // timer counts WAIT_DONE cycles including the done cycle; done beats expiry
            timer <= timer_inc_c;
            if (cur_done_c) begin
              state <= ADVANCE;
            end else if (timer_inc_c == TW'(TIMEOUT_CYCLES - 1)) begin
              state <= ERROR;
            end
          end
          ADVANCE: begin
            buf_sel <= ~buf_sel;
`ifdef LAYER_SEQ_PROFILE_EN
            layer_cycles <= 32'(timer);
`endif
            if (cur_last_c || (layer_idx == LW'(NUM_LAYERS - 1))) begin
              state <= FINISH;
            end else begin
              layer_idx <= layer_idx + LW'(1);
              state     <= ISSUE;
            end
          end
          FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          ERROR: begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef LAYER_SEQ_PROFILE_EN
  // Busy-cycle counter: cleared by an accepted run, saturating, holds in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_cycles <= '0;
    end else if (state == IDLE) begin
      if (run) begin
        total_cycles <= '0;
      end
    end else if (total_cycles != '1) begin
      total_cycles <= total_cycles + 32'd1;
    end
  end
`endif

endmodule
